// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and constants for the CPU memory subsystem
package mycpu_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACC, ARB_WAIT, ARB_DONE} arb_state_t;
  localparam int ARB_NREQ = 2;
  localparam int ARB_CPU = 0;
  localparam int ARB_LDR = 1;
  localparam int ARB_CNT_W = 16;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// arb_rr_pick: combinational two-way round-robin picker; a tie goes to the requester that did not win last
module arb_rr_pick
  import mycpu_pkg::*;
(
  input  logic [ARB_NREQ-1:0] req_i,
  input  logic                last_owner_i,
  output logic [ARB_NREQ-1:0] gnt_o,
  output logic                owner_o
);
  assign owner_o = req_i[ARB_LDR] & (~req_i[ARB_CPU] | ~last_owner_i);
  assign gnt_o = ~|req_i ? 2'b00 : owner_o ? 2'b10 : 2'b01;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer for the single-port data memory (CPU port 0, loader port 1)
// Define MEM_ARB_STATS_EN to add per-requester saturating transfer counters (stats_clr, gnt_cnt).
module mem_arbiter
  import mycpu_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_NREQ-1:0]  req,
  input  logic [ARB_NREQ-1:0]  we,
  input  logic [2*AW-1:0]      addr,
  input  logic [2*DW-1:0]      wdata,
  output logic [ARB_NREQ-1:0]  gnt,
  output logic [ARB_NREQ-1:0]  done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
`ifdef MEM_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [2*ARB_CNT_W-1:0] gnt_cnt,
`endif
  output logic [DW-1:0]        rdata
);
  arb_state_t state_q, state_d;
  logic last_owner_q, last_owner_d, owner_q, owner_d, we_q, we_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [ARB_NREQ-1:0] done_q, done_d, pick_gnt, owner_oh;
  logic pick_owner, xfer;

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
    $error("mem_arbiter: RD_LAT must be within 1..15");
  end

  arb_rr_pick u_pick (
    .req_i       (req),
    .last_owner_i(last_owner_q),
    .gnt_o       (pick_gnt),
    .owner_o     (pick_owner)
  );

  assign gnt = (state_q == ARB_IDLE) ? pick_gnt : '0;
  assign xfer = |(req & gnt);
  assign owner_oh = owner_q ? 2'b10 : 2'b01;
  assign mem_en = state_q == ARB_ACC;
  assign mem_we = mem_en & we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done = done_q;
  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    last_owner_d = last_owner_q;
    owner_d = owner_q;
    we_d = we_q;
    wait_cnt_d = wait_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    done_d = '0;
    case (state_q)
      ARB_IDLE: if (xfer) begin
        state_d = ARB_ACC;
        owner_d = pick_owner;
        last_owner_d = pick_owner;
        we_d = we[pick_owner];
        mem_addr_d = pick_owner ? addr[2*AW-1:AW] : addr[AW-1:0];
        mem_wdata_d = pick_owner ? wdata[2*DW-1:DW] : wdata[DW-1:0];
      end
      ARB_ACC: begin
        state_d = we_q ? ARB_DONE : ARB_WAIT;
        wait_cnt_d = 4'(RD_LAT - 1);
        done_d = we_q ? owner_oh : '0;
      end
      // done is registered on the transition into ARB_DONE so it leaves a flop
      ARB_WAIT: if (wait_cnt_q == 4'd0) begin
        state_d = ARB_DONE;
        rdata_d = mem_rdata;
        done_d = owner_oh;
      end else begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_owner_q <= 1'b1;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      last_owner_q <= last_owner_d;
      owner_q <= owner_d;
      we_q <= we_d;
      wait_cnt_q <= wait_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
    end

`ifdef MEM_ARB_STATS_EN
  logic [ARB_NREQ-1:0][ARB_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

  // a transfer coinciding with a clear leaves the counter at 1
  always_comb begin
    for (int i = 0; i < ARB_NREQ; i++)
      gnt_cnt_d[i] = stats_clr ? {{(ARB_CNT_W-1){1'b0}}, req[i] & gnt[i]} :
                     (req[i] & gnt[i] & ~&gnt_cnt_q[i]) ? gnt_cnt_q[i] + 1'b1 : gnt_cnt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gnt_cnt_q <= '0;
    else gnt_cnt_q <= gnt_cnt_d;

  assign gnt_cnt = gnt_cnt_q;
`endif
endmodule
